// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples PC, runs a req/ack handshake with instruction memory
// and holds the returned instruction for decode under valid/ready, with flush and timeout.
module fetch_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        pc_advance,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d  = pc & 16'hFFFE;
        cnt_d   = 8'd0;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && !flush) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (imem_ack) begin
          state_d = IDLE;
        end else if (flush) begin
          // Request cannot be withdrawn; wait out the stale ack.
          state_d = DRAIN;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        // Flush wins over ready: the held instruction is on the wrong path.
        pc_advance = valid_q & instr_ready & ~flush;
        if (flush || instr_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetches with a scoreboard queue,
// plus hand sequences for flush, flush+ready, timeout and asynchronous reset.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] pc;
  logic        flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_advance;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          waits;
    logic [15:0] data;
    int          stall;
    logic [15:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  vec_t vecs[5];
  exp_t exp_q[$];

  fetch_unit #(.TIMEOUT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_advance  (pc_advance),
    .fetch_err   (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after the instruction is accepted.
  task automatic fetch_txn(input vec_t v);
    int          n;
    logic [15:0] a;
    exp_t        e;
    exp_q.push_back('{addr: v.exp_addr, data: v.data});
    n = 0;
    next_cycle();
    while (imem_req !== 1'b1 && n < 8) begin
      next_cycle();
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("req_latency", 32'(n), 32'd0);
    a = imem_addr;
    for (int w = 0; w < v.waits; w++) begin
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'(a));
      chk("wait_err", 32'(fetch_err), 32'd0);
      next_cycle();
    end
    imem_ack   = 1'b1;
    imem_rdata = v.data;
    next_cycle();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    e = exp_q.pop_front();
    chk("addr", 32'(a), 32'(e.addr));
    chk("instr", 32'(instr), 32'(e.data));
    chk("valid", 32'(instr_valid), 32'd1);
    for (int s = 0; s < v.stall; s++) begin
      imem_ack    = 1'b1;
      imem_rdata  = 16'hBAD0;
      instr_ready = 1'b0;
      #1;
      chk("stall_adv", 32'(pc_advance), 32'd0);
      chk("stall_instr", 32'(instr), 32'(e.data));
      chk("stall_valid", 32'(instr_valid), 32'd1);
      next_cycle();
    end
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    instr_ready = 1'b1;
    #1;
    chk("advance", 32'(pc_advance), 32'd1);
    chk("accept_instr", 32'(instr), 32'(e.data));
    next_cycle();
    instr_ready = 1'b0;
    pc          = pc + 16'd2;
    chk("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{waits: 0, data: 16'h1234, stall: 0, exp_addr: 16'h0000};
    vecs[1] = '{waits: 3, data: 16'hABCD, stall: 5, exp_addr: 16'h0002};
    vecs[2] = '{waits: 1, data: 16'h0F0F, stall: 1, exp_addr: 16'h0004};
    vecs[3] = '{waits: 0, data: 16'hFFFF, stall: 2, exp_addr: 16'h0006};
    vecs[4] = '{waits: 2, data: 16'h8001, stall: 0, exp_addr: 16'h0008};

    reset       = 1'b0;
    pc          = 16'h0000;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    instr_ready = 1'b0;
    repeat (2) next_cycle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_adv", 32'(pc_advance), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) fetch_txn(vecs[i]);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush in the second FETCH cycle, stale ack two cycles later.
    next_cycle();
    chk("fl_req", 32'(imem_req), 32'd1);
    chk("fl_addr", 32'(imem_addr), 32'h000A);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    pc = 16'h0040;
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", 32'(imem_addr), 32'h000A);
    chk("drain_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    flush      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    chk("drain_req2", 32'(imem_req), 32'd1);
    chk("drain_addr2", 32'(imem_addr), 32'h000A);
    next_cycle();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    chk("postdrain_valid", 32'(instr_valid), 32'd0);
    chk("postdrain_req", 32'(imem_req), 32'd0);
    next_cycle();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'h0040);
    chk("refetch_valid", 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 16'h5555;
    next_cycle();
    imem_ack = 1'b0;
    chk("refetch_instr", 32'(instr), 32'h5555);

    // Flush and ready together in HOLD.
    instr_ready = 1'b1;
    flush       = 1'b1;
    #1;
    chk("flrdy_adv", 32'(pc_advance), 32'd0);
    next_cycle();
    instr_ready = 1'b0;
    flush       = 1'b0;
    pc          = 16'h0100;
    chk("flrdy_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", 32'(imem_addr), 32'h0100);
    imem_ack   = 1'b1;
    imem_rdata = 16'h7777;
    next_cycle();
    imem_ack = 1'b0;
    chk("redir_instr", 32'(instr), 32'h7777);
    instr_ready = 1'b1;
    #1;
    chk("redir_adv", 32'(pc_advance), 32'd1);
    next_cycle();
    instr_ready = 1'b0;
    pc          = 16'h0102;

    // Timeout with TIMEOUT=4 and a silent memory.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_err_low", 32'(fetch_err), 32'd0);
    end
    next_cycle();
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req_drop", 32'(imem_req), 32'd0);
    next_cycle();
    chk("to_retry_req", 32'(imem_req), 32'd1);
    chk("to_retry_addr", 32'(imem_addr), 32'h0102);
    imem_ack   = 1'b1;
    imem_rdata = 16'h2222;
    next_cycle();
    imem_ack = 1'b0;
    chk("to_hold_instr", 32'(instr), 32'h2222);
    chk("to_err_sticky", 32'(fetch_err), 32'd1);

    // Asynchronous reset between edges while in HOLD.
    #1;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_instr", 32'(instr), 32'd0);
    chk("arst_err", 32'(fetch_err), 32'd0);
    pc = 16'h0007;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    chk("odd_req", 32'(imem_req), 32'd1);
    chk("odd_addr", 32'(imem_addr), 32'h0006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the LEGLite datapath. It sits directly downstream of the program counter logic. It samples the current PC, runs a req/ack handshake with the instruction memory, and holds the returned 16-bit instruction for decode under a valid/ready handshake. It tells the PC logic when to advance and discards in-flight fetches when a taken branch redirects the PC.

## Interface
- `TIMEOUT`, default 16: maximum cycles a request may stay outstanding before it is abandoned (range 2..255).
- `clock` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low. `reset==0` immediately forces the reset state.
- `pc` input, 16 bits: current program counter from the PC logic.
- `flush` input, 1 bit: taken branch; the PC is being redirected at this edge.
- `imem_req` output, 1 bit: fetch request to instruction memory.
- `imem_addr` output, 16 bits: halfword-aligned fetch address.
- `imem_ack` input, 1 bit: memory has `imem_rdata` valid this cycle.
- `imem_rdata` input, 16 bits: instruction word from memory.
- `instr` output, 16 bits: instruction presented to decode.
- `instr_valid` output, 1 bit: `instr` is valid.
- `instr_ready` input, 1 bit: decode accepts `instr` this cycle.
- `pc_advance` output, 1 bit: combinational; the PC logic may step PC+2 at this edge.
- `fetch_err` output, 1 bit: sticky timeout flag.

## Operation
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- Reset values:
  - state = IDLE.
  - `imem_req`=0, `imem_addr`=0x0000, `instr`=0x0000, `instr_valid`=0, `fetch_err`=0.
  - Timeout counter = 0.
  - `pc_advance`=0, since it is only ever asserted in HOLD.
- IDLE:
  - Latch `imem_addr <= {pc[15:1],1'b0}`; odd PCs are silently aligned down.
  - Clear the counter and go to FETCH.
- FETCH:
  - `imem_req`=1. `imem_addr` is held stable until the request ends.
  - `imem_ack` and no `flush`: `instr <= imem_rdata`, `instr_valid <= 1`, go to HOLD.
  - `imem_ack` and `flush`: discard the data, go to IDLE.
  - `flush` without ack: go to DRAIN.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without an ack: set `fetch_err`, drop `imem_req`, go to IDLE.
- DRAIN:
  - `imem_req` stays 1 with the old address. The request is never withdrawn before ack, except on timeout.
  - On `imem_ack`: discard the data, go to IDLE.
  - Further `flush` pulses are ignored.
  - The timeout rule is the same as in FETCH.
- HOLD:
  - `instr_valid`=1 and `instr` is stable.
  - `pc_advance = instr_valid & instr_ready & ~flush`.
  - On accept (`instr_ready` with no `flush`): `instr_valid <= 0`, go to IDLE.
  - On `flush`: `instr_valid <= 0`, go to IDLE. No `pc_advance`; flush has priority over ready.
- `fetch_err` clears only on reset. Fetching continues after an error.
- `imem_rdata` is ignored whenever `imem_ack`=0 or the state is not FETCH/DRAIN. A spurious `imem_ack` in IDLE or HOLD is ignored.

## Timing
- Zero-wait memory (ack in the first FETCH cycle), cycle by cycle:
  - Cycle 0: IDLE.
  - Cycle 1: FETCH, ack arrives.
  - Cycle 2: HOLD with `instr_valid`=1.
- Throughput: one instruction per 3 cycles with zero-wait memory and an always-ready decode. Each memory wait cycle adds 1.
- `pc_advance` and `flush` coincide with the edge at which the PC logic updates. IDLE samples `pc` on the following edge, so it always sees the updated PC.
- Asynchronous reset mid-request drops `imem_req` immediately. The memory must tolerate an abandoned request.
- Counter width is 8 bits. It never wraps because the timeout fires first.

## Test plan
- Basic fetch: release reset with `pc`=0x0000, memory acks on the first request cycle with 0x1234, `instr_ready`=1.
  - Required: `imem_req`=1 with `imem_addr`=0x0000 in cycle 1.
  - Required: `instr`=0x1234 with `instr_valid`=1 in cycle 2.
  - Required: `pc_advance`=1 in cycle 2.
  - Required: next request at 0x0002 in cycle 4.
- Wait states and backpressure: memory acks after 3 wait cycles, `instr_ready` is held 0 for 5 cycles.
  - Required: `imem_addr` is constant through the wait.
  - Required: `instr` holds its value and `pc_advance`=0 until ready is raised.
- Flush while waiting: assert `flush` in the second FETCH cycle, ack 2 cycles later with 0xDEAD, PC now 0x0040.
  - Required: `instr_valid` never goes to 1 for 0xDEAD.
  - Required: DRAIN keeps `imem_req`=1 until the ack.
  - Required: the next request is at 0x0040.
- Flush and ready together in HOLD.
  - Required: `pc_advance`=0 and `instr_valid` drops the next cycle.
  - Required: a refetch from the redirected PC follows.
- Timeout: `TIMEOUT`=4, memory never acks.
  - Required: `fetch_err`=1 after 4 FETCH cycles, and `imem_req` drops.
  - Required: a new request starts 2 cycles later.
  - Required: `fetch_err` stays 1 until `reset`=0.
- Asynchronous reset mid-HOLD: pulse `reset` low between clock edges.
  - Required: `instr_valid`, `imem_req` and `instr` go to 0 without waiting for a clock edge.
  - Required: the first request after release is at `{pc[15:1],0}`; an odd PC of 0x0007 gives 0x0006.
